// File: rtl/mem_resp.sv
// mem_resp: bridges a 32-bit word-oriented memory controller to a 16-bit
// asynchronous SRAM. Each word access is split into a LO and a HI half-word
// access, and each half lasts WAIT clock cycles. A one-deep pending register
// holds a read request that arrives while the block is busy.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   addr             32-bit word address (15 bits)
//   fromCPU          write data word
//   wRAM             write request level, held until saverdy
//   readstart        one-cycle read request pulse
//   toCPU            read data word, valid while readrdy is high
//   readrdy          one-cycle read completion pulse
//   saverdy          one-cycle write completion pulse
//   ovr              sticky: a read request was dropped
//   sram_addr        half-word SRAM address {word_addr, hi/lo}
//   sram_dq_out      SRAM write data
//   sram_dq_oe       SRAM data bus drive enable
//   sram_dq_in       SRAM read data
//   sram_ce_n/oe_n/we_n  active-low SRAM strobes
module mem_resp #(
    // Cycles per half-word access; legal range 2..15.
    parameter int unsigned WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] addr,
    input  logic [31:0] fromCPU,
    input  logic        wRAM,
    input  logic        readstart,
    output logic [31:0] toCPU,
    output logic        readrdy,
    output logic        saverdy,
    output logic        ovr,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);
    // Counter value one cycle before the last cycle of a phase.
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WAIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RD_DONE,
        WR_LO,
        WR_HI,
        WR_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [14:0]      word_addr;
    logic [31:0]      wdata;
    logic             pending;
    logic [14:0]      pend_addr;
    logic [14:0]      rd_addr_c;

    // A queued read takes priority over a fresh request arriving in IDLE.
    assign rd_addr_c = pending ? pend_addr : addr;

    // Sequencer; every output is registered and set for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            word_addr   <= '0;
            wdata       <= '0;
            pending     <= 1'b0;
            pend_addr   <= '0;
            toCPU       <= '0;
            readrdy     <= 1'b0;
            saverdy     <= 1'b0;
            ovr         <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            readrdy <= 1'b0;
            saverdy <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (wRAM) begin
                        state       <= WR_LO;
                        cnt         <= '0;
                        word_addr   <= addr;
                        wdata       <= fromCPU;
                        sram_addr   <= {addr, 1'b0};
                        sram_dq_out <= fromCPU[15:0];
                        sram_dq_oe  <= 1'b1;
                        sram_ce_n   <= 1'b0;
                        sram_oe_n   <= 1'b1;
                        sram_we_n   <= 1'b0;
                        // A read arriving alongside the write is queued.
                        if (readstart) begin
                            if (pending) begin
                                ovr <= 1'b1;
                            end else begin
                                pending   <= 1'b1;
                                pend_addr <= addr;
                            end
                        end
                    end else if (pending || readstart) begin
                        state      <= RD_LO;
                        cnt        <= '0;
                        word_addr  <= rd_addr_c;
                        sram_addr  <= {rd_addr_c, 1'b0};
                        sram_dq_oe <= 1'b0;
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= 1'b0;
                        sram_we_n  <= 1'b1;
                        // Servicing the queued read frees the slot for a new one.
                        pending    <= pending & readstart;
                        if (pending && readstart) begin
                            pend_addr <= addr;
                        end
                    end
                end

                RD_LO: begin
                    if (cnt == CNT_LAST) begin
                        toCPU[15:0] <= sram_dq_in;
                        state       <= RD_HI;
                        cnt         <= '0;
                        sram_addr   <= {word_addr, 1'b1};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RD_HI: begin
                    if (cnt == CNT_LAST) begin
                        toCPU[31:16] <= sram_dq_in;
                        state        <= RD_DONE;
                        cnt          <= '0;
                        readrdy      <= 1'b1;
                        sram_ce_n    <= 1'b1;
                        sram_oe_n    <= 1'b1;
                        sram_we_n    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RD_DONE: begin
                    state <= IDLE;
                end

                WR_LO: begin
                    if (cnt == CNT_LAST) begin
                        state       <= WR_HI;
                        cnt         <= '0;
                        sram_addr   <= {word_addr, 1'b1};
                        sram_dq_out <= wdata[31:16];
                        sram_we_n   <= 1'b0;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        // Release we_n on the final cycle so data is stable at its rising edge.
                        sram_we_n <= (cnt == CNT_PRE);
                    end
                end

                WR_HI: begin
                    if (cnt == CNT_LAST) begin
                        state      <= WR_DONE;
                        cnt        <= '0;
                        saverdy    <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        sram_we_n <= (cnt == CNT_PRE);
                    end
                end

                WR_DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Requests arriving while busy go to the one-deep queue or are dropped.
            if (state != IDLE && readstart) begin
                if (pending) begin
                    ovr <= 1'b1;
                end else begin
                    pending   <= 1'b1;
                    pend_addr <= addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed bench for mem_resp. A WAIT=2 instance is backed by a
// 64K x 16 SRAM model; a WAIT=15 instance reads a fixed pattern (~address).
// Table of read/write vectors, then hand sequences for the multi-cycle cases.
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] addr;
    logic [31:0] fromCPU;
    logic        wRAM;
    logic        readstart;

    logic [31:0] toCPU;
    logic        readrdy, saverdy, ovr;
    logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [31:0] toCPU15;
    logic        readrdy15, saverdy15, ovr15;
    logic [15:0] sram_addr15, sram_dq_out15, sram_dq_in15;
    logic        sram_dq_oe15, sram_ce_n15, sram_oe_n15, sram_we_n15;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_resp #(.WAIT(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(toCPU), .readrdy(readrdy), .saverdy(saverdy),
        .ovr(ovr), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mem_resp #(.WAIT(15)) dut15 (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(toCPU15), .readrdy(readrdy15), .saverdy(saverdy15),
        .ovr(ovr15), .sram_addr(sram_addr15), .sram_dq_out(sram_dq_out15),
        .sram_dq_oe(sram_dq_oe15), .sram_dq_in(sram_dq_in15), .sram_ce_n(sram_ce_n15),
        .sram_oe_n(sram_oe_n15), .sram_we_n(sram_we_n15)
    );

    // SRAM model for the WAIT=2 instance, with a bench preload port.
    logic [15:0] mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end

    assign sram_dq_in   = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;
    assign sram_dq_in15 = (!sram_ce_n15 && !sram_oe_n15) ? ~sram_addr15 : 16'h0000;

    typedef struct {
        bit          wr;
        logic [14:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic do_read(input logic [14:0] a, output int lat, output logic [31:0] data);
        addr      = a;
        readstart = 1'b1;
        tick();
        readstart = 1'b0;
        addr      = 15'h1234;
        lat       = 1;
        while (!readrdy && lat < 100) begin
            tick();
            lat++;
        end
        data = toCPU;
    endtask

    task automatic do_write(input logic [14:0] a, input logic [31:0] d,
                            output int lat, output logic [3:0] web);
        addr    = a;
        fromCPU = d;
        wRAM    = 1'b1;
        web     = '0;
        tick();
        lat = 1;
        while (!saverdy && lat < 100) begin
            if (lat <= 4) web[2'(lat - 1)] = sram_we_n;
            tick();
            lat++;
        end
        wRAM = 1'b0;
    endtask

    initial begin
        vec_t        vecs [6];
        int          lat;
        logic [31:0] data;
        logic [3:0]  web;
        int          t_sv, t_rr, t_rr2, n_rr, oe_cnt;
        logic [31:0] d_rr, d_rr2;

        vecs[0] = '{wr: 1'b0, a: 15'h000A, d: 32'h0, exp: 32'hCAFEBEEF};
        vecs[1] = '{wr: 1'b1, a: 15'h7FFF, d: 32'h12345678, exp: 32'h12345678};
        vecs[2] = '{wr: 1'b0, a: 15'h7FFF, d: 32'h0, exp: 32'h12345678};
        vecs[3] = '{wr: 1'b1, a: 15'h0000, d: 32'hA5A55A5A, exp: 32'hA5A55A5A};
        vecs[4] = '{wr: 1'b0, a: 15'h0000, d: 32'h0, exp: 32'hA5A55A5A};
        vecs[5] = '{wr: 1'b0, a: 15'h0003, d: 32'h0, exp: 32'h80000001};

        rst = 1'b1; addr = '0; fromCPU = '0; wRAM = 1'b0; readstart = 1'b0;
        tick();
        preload(16'h0014, 16'hBEEF);
        preload(16'h0015, 16'hCAFE);
        preload(16'h0006, 16'h0001);
        preload(16'h0007, 16'h8000);
        rst = 1'b0;
        tick();

        // Reset values
        chk("rst_toCPU", toCPU, 32'h0);
        chk("rst_pulses_ovr", {29'h0, readrdy, saverdy, ovr}, 32'h0);
        chk("rst_sram_addr", {16'h0, sram_addr}, 32'h0);
        chk("rst_dq", {15'h0, sram_dq_oe, sram_dq_out}, 32'h0);
        chk("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);

        // Table-driven reads and writes
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].a, vecs[i].d, lat, web);
                chk($sformatf("v%0d_wr_lat", i), lat, 5);
                chk($sformatf("v%0d_we_n", i), {28'h0, web}, 32'hA);
                chk($sformatf("v%0d_mem_lo", i), {16'h0, mem[{vecs[i].a, 1'b0}]}, {16'h0, vecs[i].exp[15:0]});
                chk($sformatf("v%0d_mem_hi", i), {16'h0, mem[{vecs[i].a, 1'b1}]}, {16'h0, vecs[i].exp[31:16]});
                tick();
                chk($sformatf("v%0d_saverdy_pulse", i), {31'h0, saverdy}, 32'h0);
            end else begin
                do_read(vecs[i].a, lat, data);
                chk($sformatf("v%0d_rd_lat", i), lat, 5);
                chk($sformatf("v%0d_rd_data", i), data, vecs[i].exp);
                tick();
                chk($sformatf("v%0d_readrdy_pulse", i), {31'h0, readrdy}, 32'h0);
                chk($sformatf("v%0d_idle_strobes", i), {28'h0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
            end
        end

        // Write and read in the same IDLE cycle: write first, then queued read
        addr = 15'h0005; fromCPU = 32'h0BADF00D; wRAM = 1'b1; readstart = 1'b1;
        t_sv = 0; t_rr = 0; d_rr = '0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            readstart = 1'b0;
            if (saverdy && t_sv == 0) begin t_sv = n; wRAM = 1'b0; end
            if (readrdy && t_rr == 0) begin t_rr = n; d_rr = toCPU; end
            if (saverdy && readrdy) chk("both_rdy", 32'h1, 32'h0);
        end
        chk("conc_saverdy_t", t_sv, 5);
        chk("conc_readrdy_t", t_rr, 11);
        chk("conc_data", d_rr, 32'h0BADF00D);

        // Three reads during one: second queued, third dropped
        chk("ovr_before", {31'h0, ovr}, 32'h0);
        addr = 15'h000A; readstart = 1'b1;
        n_rr = 0; t_rr = 0; t_rr2 = 0; d_rr = '0; d_rr2 = '0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) addr = 15'h0003;
            if (n == 2) addr = 15'h7FFF;
            if (n == 3) readstart = 1'b0;
            if (readrdy) begin
                n_rr++;
                if (n_rr == 1) begin t_rr = n; d_rr = toCPU; end
                if (n_rr == 2) begin t_rr2 = n; d_rr2 = toCPU; end
            end
        end
        chk("ovr3_count", n_rr, 2);
        chk("ovr3_t1", t_rr, 5);
        chk("ovr3_d1", d_rr, 32'hCAFEBEEF);
        chk("ovr3_t2", t_rr2, 11);
        chk("ovr3_d2", d_rr2, 32'h80000001);
        chk("ovr_sticky", {31'h0, ovr}, 32'h1);

        // Reset in the middle of RD_HI
        addr = 15'h000A; readstart = 1'b1;
        tick();
        readstart = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_toCPU", toCPU, 32'h0);
        chk("mid_rst_strobes", {28'h0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        chk("mid_rst_ovr", {31'h0, ovr}, 32'h0);
        n_rr = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (readrdy) n_rr++;
        end
        chk("mid_rst_no_rdy", n_rr, 0);
        do_read(15'h0003, lat, data);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_data", data, 32'h80000001);

        // WAIT=15 instance: 31-cycle latency, oe_n low for 30 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr = 15'h000A; readstart = 1'b1;
        tick();
        readstart = 1'b0;
        lat = 1; oe_cnt = 0;
        while (!readrdy15 && lat < 100) begin
            if (!sram_oe_n15) oe_cnt++;
            tick();
            lat++;
        end
        chk("w15_lat", lat, 31);
        chk("w15_oe_cycles", oe_cnt, 30);
        chk("w15_data", toCPU15, 32'hFFEAFFEB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
